// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU byte-bus responder serving on-chip RAM, UART TX FIFO, RX holding byte, cycle counter and stop flag
module mem_io_responder #(
    parameter int ADDR_WIDTH   = 17,
    parameter int TX_DEPTH_LOG = 3,
    parameter int FULL_MARGIN  = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        halted
);
    localparam int DEPTH = 1 << TX_DEPTH_LOG;
    localparam logic [TX_DEPTH_LOG:0] DEPTH_C  = (TX_DEPTH_LOG + 1)'(DEPTH);
    localparam logic [TX_DEPTH_LOG:0] MARGIN_C = (TX_DEPTH_LOG + 1)'(FULL_MARGIN);

    logic [7:0]              mem [2**ADDR_WIDTH];
    logic [7:0]              tx_buf [DEPTH];
    logic [17:0]             a;
    logic                    is_io, rd_rx, rd_cnt, push_req, stop, pop, push, rx_fire;
    logic [7:0]              push_data, io_dat_d;
    logic [TX_DEPTH_LOG:0]   count_d;
    logic [31:0]             cnt_q, snap_q;
    logic                    rx_full_q, halted_q, full_q, rd_q, io_q;
    logic [7:0]              rx_byte_q, io_dat_q, ram_q, din_q;
    logic [TX_DEPTH_LOG-1:0] wp_q, rp_q;
    logic [TX_DEPTH_LOG:0]   count_q;
    logic                    unused_a;

    assign a         = cpu_a[17:0];
    assign unused_a  = ^cpu_a[31:18];
    assign is_io     = a[17:16] == 2'b11;
    assign tx_valid  = count_q != '0;
    assign tx_data   = tx_valid ? tx_buf[rp_q] : 8'h00;
    assign rx_ready  = !rx_full_q;
    assign halted    = halted_q;
    assign cpu_din   = din_q;
    assign io_buffer_full = full_q;

    // Request decode, FIFO handshake and I/O read data for this cycle
    always_comb begin
        rd_rx     = !cpu_wr && a == 18'h30000;
        rd_cnt    = !cpu_wr && a == 18'h30004;
        stop      = cpu_wr && a == 18'h30004;
        push_req  = stop || (cpu_wr && a == 18'h30000 && cpu_dout != 8'h00);
        push_data = stop ? 8'h00 : cpu_dout;
        pop       = tx_valid && tx_ready;
        push      = push_req && (count_q < DEPTH_C || pop);
        count_d   = count_q + (TX_DEPTH_LOG + 1)'(push) - (TX_DEPTH_LOG + 1)'(pop);
        rx_fire   = rx_valid && !rx_full_q;
        io_dat_d  = a == 18'h30000 ? (rx_full_q ? rx_byte_q : 8'h00) :
                    a == 18'h30004 ? cnt_q[7:0] :
                    a == 18'h30005 ? snap_q[15:8] :
                    a == 18'h30006 ? snap_q[23:16] :
                    a == 18'h30007 ? snap_q[31:24] : 8'h00;
    end

    // Storage arrays: RAM write plus registered read, TX FIFO entry write
    always_ff @(posedge clk_in) begin
        if (!is_io && cpu_wr) mem[cpu_a[ADDR_WIDTH-1:0]] <= cpu_dout;
        ram_q <= mem[cpu_a[ADDR_WIDTH-1:0]];
        if (push) tx_buf[wp_q] <= push_data;
    end

    // Control state: counter, snapshot, RX holding, FIFO pointers, stop flag, read pipeline
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q     <= '0;
            snap_q    <= '0;
            rx_full_q <= 1'b0;
            rx_byte_q <= '0;
            halted_q  <= 1'b0;
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            rd_q      <= 1'b0;
            io_q      <= 1'b0;
            io_dat_q  <= '0;
            din_q     <= '0;
        end else begin
            cnt_q     <= cnt_q + 32'd1;
            snap_q    <= rd_cnt ? cnt_q : snap_q;
            rx_full_q <= rx_fire ? 1'b1 : (rd_rx ? 1'b0 : rx_full_q);
            rx_byte_q <= rx_fire ? rx_data : (rd_rx ? 8'h00 : rx_byte_q);
            halted_q  <= halted_q || stop;
            wp_q      <= push ? wp_q + TX_DEPTH_LOG'(1) : wp_q;
            rp_q      <= pop ? rp_q + TX_DEPTH_LOG'(1) : rp_q;
            count_q   <= count_d;
            full_q    <= (DEPTH_C - count_d) <= MARGIN_C;
            rd_q      <= !cpu_wr;
            io_q      <= is_io;
            io_dat_q  <= io_dat_d;
            din_q     <= rd_q ? (io_q ? io_dat_q : ram_q) : din_q;
        end
    end
endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Responder end of the CPU byte bus: it decodes each cycle's address and write flag and serves the request from on-chip RAM or the I/O space. It provides the 128 KB main memory, the UART transmit FIFO behind `io_buffer_full`, a one-byte UART receive holding register, the free-running cycle counter and the program-stop flag. It sits between `cpu` and the UART/board logic in the top-level SoC.

## Interface
- `ADDR_WIDTH`, 17: RAM index width; RAM holds 2^ADDR_WIDTH bytes.
- `TX_DEPTH_LOG`, 3: TX FIFO depth is 2^TX_DEPTH_LOG entries.
- `FULL_MARGIN`, 2: `io_buffer_full` asserts when the number of free TX entries is at most FULL_MARGIN.
- `clk_in` in 1: the single clock.
- `rst_in` in 1: synchronous, active-high reset.
- `cpu_a` in 32: byte address. Only bits [17:0] are decoded.
- `cpu_wr` in 1: 1 = write, 0 = read.
- `cpu_dout` in 8: write data driven by the CPU.
- `cpu_din` out 8: read data returned to the CPU.
- `io_buffer_full` out 1: TX FIFO is nearly full.
- `tx_valid` out 1, `tx_data` out 8, `tx_ready` in 1: byte stream to the UART transmitter.
- `rx_valid` in 1, `rx_data` in 8, `rx_ready` out 1: byte stream from the UART receiver.
- `halted` out 1: sticky program-stop flag.

## Operation
- **Request timing.** Every cycle is one request. There is no idle encoding, and there is no stall and no back-pressure toward the CPU.
- **Address decode.**
  - `cpu_a[17:16]==2'b11` selects I/O space.
  - Any other address selects RAM at index `cpu_a[ADDR_WIDTH-1:0]`.
- **RAM.**
  - A write stores `cpu_dout`.
  - A read registers the addressed byte onto `cpu_din`.
  - RAM contents are not reset.
- **I/O read, 0x30000.**
  - Returns the RX holding byte, or 0x00 if the holding register is empty.
  - Empties the holding register.
- **I/O read, 0x30004.**
  - Latches the 32-bit cycle counter into `snap`.
  - Returns `snap[7:0]` computed from the live counter value.
- **I/O read, 0x30005 / 0x30006 / 0x30007.** Returns `snap[15:8]`, `snap[23:16]` and `snap[31:24]` respectively, without re-latching.
- **Other I/O reads.** Return 0x00.
- **I/O write, 0x30000.**
  - Pushes `cpu_dout` into the TX FIFO.
  - A value of 0x00 is ignored.
- **I/O write, 0x30004.**
  - Pushes 0x00 into the TX FIFO (this bypasses the zero-ignore rule).
  - Sets `halted`.
- **Other I/O writes.** Ignored.
- **Cycle counter.**
  - 32 bits, increments every cycle after reset.
  - Wraps from 0xFFFFFFFF to 0.
- **RX holding register.**
  - `rx_ready` = holding register empty.
  - The byte is captured when `rx_valid && rx_ready`.
- **TX FIFO.**
  - Circular buffer with read pointer, write pointer and count.
  - `tx_valid` = count != 0; `tx_data` = the head entry.
  - Pop when `tx_valid && tx_ready`.
  - A push is accepted when count < DEPTH, or when a pop happens in the same cycle.
  - A push into a full FIFO with no simultaneous pop is dropped silently.
  - Pointers wrap modulo DEPTH.
- **`io_buffer_full`.** Registered from the next-state count: asserted when DEPTH − count_next ≤ FULL_MARGIN.
- **Reset.**
  - Clears counter, `snap`, FIFO pointers and count, holding register, `halted`, `cpu_din` and `io_buffer_full`.
  - The outputs `tx_valid`, `tx_data`, `halted`, `cpu_din` and `io_buffer_full` all read 0.
  - `rx_ready` reads 1.
  - Reset asserted mid-stream discards any queued TX bytes and any pending RX byte.

## Timing
- **Read latency.**
  - Address sampled at edge N produces `cpu_din` valid after edge N+1; the CPU samples it at edge N+2.
  - `cpu_din` holds its value until the next read.
  - A write cycle leaves `cpu_din` unchanged.
- **Write then read.** A write at edge N followed by a read of the same address at edge N+1 returns the new data.
- **I/O side effects.** All take effect at the sampling edge: FIFO push, `halted` set, `snap` latch, holding-register clear.
- **Counter value.** The counter reads 0 in the first cycle after reset release.
- **RX read and arrival in the same cycle, holding register full.**
  - The read returns the old byte and clears the register.
  - The new byte is not accepted that cycle (`rx_ready` was low); it is captured in the following cycle.
- **TX push and pop in the same cycle.** Count is unchanged.
- **`halted`.** Once set, it stays set until reset; further requests are still served.

## Test plan
- **RAM.** Write 0xA5 to 0x00010, then read 0x00010 the next cycle → `cpu_din`=0xA5 one cycle after the read address.
- **TX path.** Hold `tx_ready`=0; write 'H','i',0x00 to 0x30000.
  - → count=2; 0x00 is ignored.
  - → with DEPTH=8 and FULL_MARGIN=2, `io_buffer_full` asserts after the 6th push.
  - → the 9th push is dropped.
  - → after releasing `tx_ready`, bytes drain in order.
- **Cycle counter.** Read 0x30004 at cycle 100 after reset, then read 0x30005–0x30007 → bytes 0x64, 0x00, 0x00, 0x00.
- **RX path.** Pulse `rx_valid` with 0x41, then read 0x30000 twice → 0x41, then 0x00; `rx_ready` returns high after the first read.
- **Stop.** Write 0x30004 with any data → `halted`=1 next cycle and a 0x00 byte appears on the TX stream.
- **Reset mid-stream.** Assert `rst_in` with 3 bytes queued → `tx_valid`=0, `halted`=0 and counter=0 after the reset edge.
